// File: rtl/conv_window_gen.sv
// conv_window_gen
//   Reads one image frame from a registered-output ROM in raster order and
//   emits every fully populated 3x3 neighbourhood as a window. Two line
//   buffers hold the previous two image rows. A 3x3 shift register forms the
//   window, and a valid/ready handshake carries it downstream.
//
// Ports
//   clk, rstn       clock, asynchronous active-low reset
//   start           one-cycle frame request; only sampled while idle
//   busy            frame in progress
//   done            one-cycle pulse with the handshake of the final window
//   rom_aa          ROM pixel address (raster order)
//   rom_cena        ROM read enable, active-low
//   rom_qa          ROM read data, one cycle after an enabled read
//   win_valid       window valid
//   win_ready       downstream accepts the window
//   win_data        9 taps; tap r*3+c at [(i+1)*DW-1 : i*DW], r/c = 0 top/left
//   win_row/win_col output-map coordinate of the window's top-left pixel
//
// Image dimensions are limited to 32x32 by the 5-bit coordinate ports.

`ifndef WD
`define WD 7
`endif

module conv_window_gen #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int DW    = `WD+1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [11:0]     rom_aa,
  output logic            rom_cena,
  input  logic [DW-1:0]   rom_qa,
  output logic            win_valid,
  input  logic            win_ready,
  output logic [9*DW-1:0] win_data,
  output logic [4:0]      win_row,
  output logic [4:0]      win_col
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  localparam logic [11:0] LAST_AA  = 12'(IMG_W*IMG_H-1);
  localparam logic [4:0]  COL_LAST = 5'(IMG_W-1);
  localparam logic [4:0]  LAST_WR  = 5'(IMG_H-3);
  localparam logic [4:0]  LAST_WC  = 5'(IMG_W-3);

  state_t                state_q, state_d;
  logic [11:0]           aa_q, aa_d;
  logic                  pend_q, pend_d;
  logic [4:0]            col_q, col_d;
  logic [4:0]            row_q, row_d;
  logic [8:0][DW-1:0]    win_q, win_d;
  logic                  wv_q, wv_d;
  logic [4:0]            wrow_q, wrow_d;
  logic [4:0]            wcol_q, wcol_d;

  logic [DW-1:0]         lb0 [0:IMG_W-1];
  logic [DW-1:0]         lb1 [0:IMG_W-1];

  logic                  advance;
  logic                  issue;
  logic                  consume;
  logic                  handshake;
  logic                  last_win;

  // A held window freezes the whole pipeline, including ROM reads, so the
  // registered ROM output stays valid until it can be consumed.
  always_comb begin
    advance   = !wv_q || win_ready;
    issue     = (state_q == S_FETCH) && advance;
    consume   = pend_q && advance;
    handshake = wv_q && win_ready;
    last_win  = (wrow_q == LAST_WR) && (wcol_q == LAST_WC);
  end

  assign busy      = (state_q != S_IDLE);
  // All reads have been issued in DRAIN, so the last window can only appear there.
  assign done      = (state_q == S_DRAIN) && handshake && last_win;
  assign rom_cena  = !issue;
  assign rom_aa    = aa_q;
  assign win_valid = wv_q;
  assign win_data  = win_q;
  assign win_row   = wrow_q;
  assign win_col   = wcol_q;

  always_comb begin
    state_d = state_q;
    aa_d    = aa_q;
    pend_d  = pend_q;
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    wv_d    = wv_q;
    wrow_d  = wrow_q;
    wcol_d  = wcol_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          aa_d    = '0;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_FETCH: begin
        if (issue) begin
          if (aa_q == LAST_AA) begin
            state_d = S_DRAIN;
            aa_d    = '0;
          end else begin
            aa_d = aa_q + 12'd1;
          end
        end
      end
      S_DRAIN: begin
        if (done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Issue and consume in the same cycle keep the pending flag set.
    if (issue)        pend_d = 1'b1;
    else if (consume) pend_d = 1'b0;

    if (handshake) wv_d = 1'b0;

    if (consume) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r*3]   = win_q[r*3+1];
        win_d[r*3+1] = win_q[r*3+2];
      end
      win_d[2] = lb1[col_q];
      win_d[5] = lb0[col_q];
      win_d[8] = rom_qa;

      // Requiring col >= 2 keeps windows from straddling a row wrap.
      if (row_q >= 5'd2 && col_q >= 5'd2) begin
        wv_d   = 1'b1;
        wrow_d = row_q - 5'd2;
        wcol_d = col_q - 5'd2;
      end

      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + 5'd1;
      end else begin
        col_d = col_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      aa_q    <= '0;
      pend_q  <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      wv_q    <= 1'b0;
      wrow_q  <= '0;
      wcol_q  <= '0;
    end else begin
      state_q <= state_d;
      aa_q    <= aa_d;
      pend_q  <= pend_d;
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      wv_q    <= wv_d;
      wrow_q  <= wrow_d;
      wcol_q  <= wcol_d;
    end
  end

  // Line buffers: every entry is rewritten by rows 0 and 1 before any window
  // reads it, so stale contents from an earlier frame never reach an output.
  always_ff @(posedge clk) begin
    if (consume) begin
      lb1[col_q] <= lb0[col_q];
      lb0[col_q] <= rom_qa;
    end
  end

endmodule

// File: doc/conv_window_gen.md
CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 28, image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 28, image height in pixels.
REQ-003 SHALL have parameter DW, default `WD+1, pixel width in bits.
REQ-004 clk  input  1  rising-edge clock; the block's one clock.
REQ-005 rstn  input  1  reset; asynchronous, active-low.
REQ-006 start  input  1  single-cycle request to begin one frame; sampled only in IDLE.
REQ-007 busy  output  1  high from the cycle after start is accepted until done.
REQ-008 done  output  1  one-cycle pulse at frame end.
REQ-009 rom_aa  output  12  source ROM pixel address, raster order.
REQ-010 rom_cena  output  1  ROM read enable, active-low.
REQ-011 rom_qa  input  DW  ROM registered read data; valid 1 cycle after an enabled read; held while rom_cena is high.
REQ-012 win_valid  output  1  3x3 window valid.
REQ-013 win_ready  input  1  downstream accepts the window.
REQ-014 win_data  output  9*DW  window; tap i=r*3+c at bits [(i+1)*DW-1 : i*DW]; r=0 is the top row, c=0 is the left column.
REQ-015 win_row, win_col  output  5 each  output-map coordinate of the window's top-left pixel.

Function
REQ-016 SHALL implement FSM IDLE -> FETCH -> DRAIN -> IDLE.
  - IDLE -> FETCH on start.
  - FETCH -> DRAIN after address IMG_W*IMG_H-1 is issued.
  - DRAIN -> IDLE when the last window handshakes; done pulses in the same cycle.
REQ-017 advance SHALL equal (!win_valid || win_ready); while advance is low, no read is issued, no pixel is consumed and all state holds.
REQ-018 rom_cena SHALL be low only in FETCH with advance high; rom_aa increments by 1 after each issued read, starting at 0.
REQ-019 A pending flag SHALL record an issued read; rom_qa is consumed in the first cycle with advance high after issue, including when that cycle is a stall release.
REQ-020 Each consumed pixel SHALL update the following, indexed by column counter col:
  - line buffer LB1[col] <= LB0[col];
  - LB0[col] <= pixel;
  - the 3x3 register window shifts left; the new right column is {LB1[col], LB0[col], pixel}, top to bottom.
  - col/row counters then advance raster-wise, with col wrapping at IMG_W-1.
REQ-021 A consumed pixel at row>=2 and col>=2 SHALL register win_valid=1 next cycle, with win_row=row-2 and win_col=col-2.
REQ-022 win_valid SHALL clear on handshake unless a new window is registered in the same cycle.
REQ-023 Windows SHALL NOT straddle a row wrap; no window is produced for col<2 or row<2.
REQ-024 One frame SHALL produce exactly (IMG_W-2)*(IMG_H-2) windows (676 at default), in raster order.
REQ-025 Latency with no stall, start accepted at cycle 0:
  - cycle 1: aa=0 issued;
  - pixel k consumed at cycle k+2;
  - first win_valid at cycle 61;
  - last window at cycle 786;
  - done at the cycle of the final handshake.
REQ-026 start SHALL be ignored while busy.
REQ-027 Pixel data SHALL pass through unmodified; there is no arithmetic on data.

Reset
REQ-028 While rstn is low, the block SHALL force:
  - FSM to IDLE;
  - busy=0, done=0, win_valid=0;
  - rom_cena=1, rom_aa=0;
  - win_data=0, win_row=0, win_col=0;
  - all counters and the pending flag to 0.
  Line-buffer contents need no reset.
REQ-029 Reset asserted mid-frame SHALL abort the frame without a done pulse; the next start runs a complete frame.

Verification
REQ-030 Stub ROM with qa=aa, win_ready=1, start at cycle 0 -> first window at cycle 61 with (row,col)=(0,0) and taps {0,1,2,28,29,30,56,57,58}; last window (25,25) with taps {725,726,727,753,754,755,781,782,783}; exactly 676 windows; done at cycle 786.
REQ-031 Digit image ROM -> window (5,8) taps {0,1,1,1,1,1,1,1,1}; window (0,0) all zero.
REQ-032 win_ready low for 10 cycles at window (3,4), then random 50% backpressure -> no window lost or duplicated; rom_cena stays high while stalled; sequence matches REQ-030.
REQ-033 start pulsed again at cycle 100 -> ignored; window count still 676.
REQ-034 rstn low at cycle 300, start at cycle 310 -> outputs at reset values, no done until the second frame; second frame matches REQ-030 timing relative to cycle 310.
REQ-035 Two back-to-back frames (start in the cycle after done) -> both frames are identical; no stale line-buffer data appears in any valid window.
